// File: rtl/a_rom_reader.sv
// a_rom_reader
// Sweeps the A-matrix ROM from address 0 to DEPTH-1 and streams each word
// out over a valid/ready handshake. A sweep begins on a start pulse. If the
// ROM load has not finished yet, the sweep waits for it. The ROM has one
// cycle of read latency. Reads are throttled so that every word already
// requested always has room in a 2-entry output FIFO. Because of that, a
// stalled consumer never causes a word to be dropped.
//
// Ports
//   clk        : single rising-edge clock
//   rst        : synchronous active-high reset
//   aload_done : level, high once the A ROM has been loaded
//   start      : one-cycle sweep request, honoured only when idle
//   rom_addr   : read address to the A ROM
//   rom_rdata  : ROM read data, valid one cycle after rom_addr
//   out_data   : streamed A word (FIFO head)
//   out_valid  : out_data holds a valid word
//   out_ready  : downstream accepts the word this cycle
//   out_last   : marks the word read from address DEPTH-1
//   busy       : high from start acceptance until the sweep ends
//   done       : one-cycle pulse at the end of a sweep
module a_rom_reader #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aload_done,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOAD,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;

  // One read may be outstanding in the ROM pipeline at any time.
  logic              r_inflight;
  logic              r_inflightLast;

  // Two-entry FIFO. Slot 0 is always the head.
  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_data0;
  logic [DATA_W-1:0] r_data1;
  logic              r_last0;
  logic              r_last1;

  logic              w_pop;
  logic              w_issue;
  logic              w_addrLast;
  logic [2:0]        w_occupancy;
  logic [1:0]        w_slot;

  // A word leaves the FIFO only on a completed handshake.
  assign w_pop = (r_count != 2'd0) && out_ready;

  // Count the words the FIFO will have to hold: the words already buffered
  // plus the one still in the ROM, minus the word leaving this cycle. A new
  // read is issued only if that count stays below two, so its data always
  // has a slot waiting for it.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == READ) && (w_occupancy < 3'd2);
  assign w_addrLast  = (r_addr == ADDR_W'(DEPTH - 1));

  // Slot that returning data lands in, after this cycle's pop shifts the head.
  assign w_slot = r_count - {1'b0, w_pop};

  assign rom_addr  = r_addr;
  assign out_data  = r_data0;
  assign out_last  = r_last0;
  assign out_valid = (r_count != 2'd0);
  assign busy      = r_busy;
  assign done      = r_done;

  // Sweep control FSM. It owns the read address and the busy/done outputs.
  // aload_done and start are looked at only while waiting for work, so
  // changes to them during a sweep have no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_state <= aload_done ? READ : WAIT_LOAD;
          end
        end
        WAIT_LOAD: begin
          if (aload_done) begin
            r_state <= READ;
          end
        end
        READ: begin
          if (w_issue) begin
            if (w_addrLast) begin
              r_state <= DRAIN;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_pop && r_last0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_addr  <= '0;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // ROM return path and output FIFO. The data for a read issued in one cycle
  // is captured in the next cycle. A pop shifts slot 1 into the head. A push
  // then writes whichever slot is free after that shift. A reset drops any
  // read still in flight along with the FIFO contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
      r_count        <= 2'd0;
      r_data0        <= '0;
      r_data1        <= '0;
      r_last0        <= 1'b0;
      r_last1        <= 1'b0;
    end else begin
      r_inflight     <= w_issue;
      r_inflightLast <= w_issue && w_addrLast;
      if (w_pop) begin
        r_data0 <= r_data1;
        r_last0 <= r_last1;
      end
      if (r_inflight) begin
        if (w_slot == 2'd0) begin
          r_data0 <= rom_rdata;
          r_last0 <= r_inflightLast;
        end else begin
          r_data1 <= rom_rdata;
          r_last1 <= r_inflightLast;
        end
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_a_rom_reader.sv
// tb_a_rom_reader
// Directed testbench for a_rom_reader. A behavioural ROM returns A[i] = i+1
// one cycle after each address. Every sweep that is started pushes its
// expected words onto a scoreboard queue. A negedge monitor pops an entry
// on every completed handshake and compares it with the word on the port.
module tb_a_rom_reader;

  localparam int DATA_W = 14;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              aload_done;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int xferCount = 0;
  int doneCount = 0;
  int doneBefore;

  logic [DATA_W:0]   expQ[$];
  logic              prevStall = 1'b0;
  logic [DATA_W-1:0] prevData;
  logic              prevLast;

  a_rom_reader #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .aload_done(aload_done),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM with one cycle of latency, holding A[i] = i+1.
  always @(posedge clk) begin
    rom_rdata <= DATA_W'(rom_addr) + DATA_W'(1);
  end

  // Compares an observed value with an expected one and records the result.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Moves to 1 time unit after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle and queues the 16 words the sweep must deliver.
  task automatic applyStimulus();
    start = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      expQ.push_back({(i == DEPTH - 1), DATA_W'(i + 1)});
    end
    stepCycle();
    start = 1'b0;
  endtask

  // Waits a bounded number of cycles for a done pulse. It can drive
  // out_ready randomly while waiting.
  task automatic waitDone(input int budget, input bit randReady);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (randReady) out_ready = 1'($urandom_range(0, 1));
      stepCycle();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
  endtask

  // Checks that every output holds its reset value.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
    checkOutput({tag, "_out_last"}, 32'(out_last), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Scoreboard monitor. It compares every transfer with the queue head and
  // checks that the output word holds steady while the consumer stalls.
  always @(negedge clk) begin
    logic [DATA_W:0] exp;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_data", 32'(out_data), 32'(prevData));
        checkOutput("stall_last", 32'(out_last), 32'(prevLast));
      end
      if (out_valid && out_ready) begin
        checkOutput("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          exp = expQ.pop_front();
          checkOutput("sb_data", 32'(out_data), 32'(exp[DATA_W-1:0]));
          checkOutput("sb_last", 32'(out_last), 32'(exp[DATA_W]));
        end
        xferCount++;
      end
      if (done) doneCount++;
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      prevLast  = out_last;
    end
  end

  // Directed test sequence.
  initial begin
    rst        = 1'b1;
    aload_done = 1'b1;
    start      = 1'b0;
    out_ready  = 1'b0;
    stepCycle();
    stepCycle();
    checkResetValues("reset");
    rst = 1'b0;
    stepCycle();

    // Nominal sweep with ready held high: check latency and the last/done timing.
    $display("[TB] nominal sweep");
    out_ready = 1'b1;
    applyStimulus();
    checkOutput("nom_addr_s1", 32'(rom_addr), 32'd0);
    checkOutput("nom_busy_s1", 32'(busy), 32'd1);
    checkOutput("nom_valid_s1", 32'(out_valid), 32'd0);
    stepCycle();
    checkOutput("nom_valid_s2", 32'(out_valid), 32'd0);
    stepCycle();
    checkOutput("nom_valid_s3", 32'(out_valid), 32'd1);
    checkOutput("nom_data_s3", 32'(out_data), 32'd1);
    repeat (14) stepCycle();
    checkOutput("nom_last_s17", 32'(out_last), 32'd0);
    stepCycle();
    checkOutput("nom_last_s18", 32'(out_last), 32'd1);
    checkOutput("nom_data_s18", 32'(out_data), 32'd16);
    checkOutput("nom_done_s18", 32'(done), 32'd0);
    stepCycle();
    checkOutput("nom_done_s19", 32'(done), 32'd1);
    stepCycle();
    checkOutput("nom_done_s20", 32'(done), 32'd0);
    checkOutput("nom_busy_s20", 32'(busy), 32'd0);
    checkOutput("nom_sb_empty", 32'(expQ.size()), 32'd0);

    // Start before the ROM load finishes. Later, dropping aload_done in
    // mid-sweep must have no effect.
    $display("[TB] wait for load");
    aload_done = 1'b0;
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      checkOutput("wl_busy", 32'(busy), 32'd1);
      checkOutput("wl_addr", 32'(rom_addr), 32'd0);
      checkOutput("wl_valid", 32'(out_valid), 32'd0);
      if (i < 4) stepCycle();
    end
    aload_done = 1'b1;
    stepCycle();
    checkOutput("wl_addr_w1", 32'(rom_addr), 32'd0);
    stepCycle();
    checkOutput("wl_addr_w2", 32'(rom_addr), 32'd1);
    aload_done = 1'b0;
    stepCycle();
    checkOutput("wl_valid_w3", 32'(out_valid), 32'd1);
    waitDone(60, 1'b0);
    checkOutput("wl_sb_empty", 32'(expQ.size()), 32'd0);
    aload_done = 1'b1;
    stepCycle();

    // Random backpressure.
    $display("[TB] random ready");
    xferCount = 0;
    applyStimulus();
    waitDone(200, 1'b1);
    out_ready = 1'b1;
    stepCycle();
    checkOutput("rand_xfers", 32'(xferCount), 32'd16);
    checkOutput("rand_sb_empty", 32'(expQ.size()), 32'd0);

    // A long stall right after the first word: reads must stop at address 2.
    $display("[TB] long stall");
    out_ready = 1'b0;
    applyStimulus();
    stepCycle();
    stepCycle();
    checkOutput("stall_first_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_addr", 32'(rom_addr), 32'd2);
      stepCycle();
    end
    out_ready = 1'b1;
    waitDone(60, 1'b0);
    checkOutput("stall_sb_empty", 32'(expQ.size()), 32'd0);
    stepCycle();

    // Reset on the 8th transfer, then restart from word 1.
    $display("[TB] reset mid-sweep");
    xferCount = 0;
    applyStimulus();
    for (int i = 0; i < 40 && xferCount < 7; i++) stepCycle();
    checkOutput("rst_reach_7", 32'(xferCount), 32'd7);
    rst = 1'b1;
    expQ.delete();
    doneBefore = doneCount;
    stepCycle();
    checkResetValues("midrst");
    rst = 1'b0;
    repeat (3) stepCycle();
    checkOutput("midrst_valid_after", 32'(out_valid), 32'd0);
    checkOutput("midrst_no_done", 32'(doneCount - doneBefore), 32'd0);
    applyStimulus();
    waitDone(60, 1'b0);
    stepCycle();
    checkOutput("midrst_one_done", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("midrst_sb_empty", 32'(expQ.size()), 32'd0);

    // A second start during READ is ignored.
    $display("[TB] start during read");
    doneBefore = doneCount;
    applyStimulus();
    repeat (4) stepCycle();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    waitDone(60, 1'b0);
    repeat (25) stepCycle();
    checkOutput("restart_one_done", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("restart_busy", 32'(busy), 32'd0);
    checkOutput("restart_valid", 32'(out_valid), 32'd0);
    checkOutput("restart_sb_empty", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
